// File: rtl/inport_pkg.sv
// Shared defaults and the port-index width helper for the input-port multiplexer.
package inport_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NPORTS_DEF = 4;

  // A select bus is never narrower than one bit, even for a single port.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SEL_W_DEF = sel_w(NPORTS_DEF);

endpackage

// File: rtl/inport_latch.sv
// One external input port: holding register, full flag and sticky overrun flag.
module inport_latch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  input  logic [WIDTH-1:0] din,
  input  logic             consume,
  input  logic             inhibit,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             overrun
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A consume frees the slot in the same edge, so a coincident strobe refills it.
      if (stb && (consume || (!full && !inhibit))) begin
        dout <= din;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end

      if (stb && full && !consume) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/inport_mux.sv
// Input multiplexer: internal bus or one of NPORTS buffered external ports.
// Build option INPORT_BYPASS_EN forwards a strobe on an empty selected port in the same cycle.
module inport_mux
  import inport_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NPORTS = NPORTS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          bus_d,
  input  logic [NPORTS*WIDTH-1:0]   port_data,
  input  logic [NPORTS-1:0]         port_stb,
  input  logic                      ie,
  input  logic [sel_w(NPORTS)-1:0]  port_sel,
  input  logic [NPORTS-1:0]         ovr_clr,
  output logic [WIDTH-1:0]          mux_out,
  output logic                      in_stall,
  output logic [NPORTS-1:0]         port_full,
  output logic [NPORTS-1:0]         overrun
);

  logic [NPORTS*WIDTH-1:0] hold;
  logic [NPORTS-1:0]       consume;
  logic [NPORTS-1:0]       inhibit;
  logic                    sel_full;
  logic [WIDTH-1:0]        sel_hold;
  logic                    bypass_hit;

`ifdef INPORT_BYPASS_EN
  logic                    sel_stb;
  logic [WIDTH-1:0]        sel_pdata;
`endif

  // An out-of-range select matches no port, so it reads as empty and touches no state.
  always_comb begin
    sel_full = 1'b0;
    sel_hold = '0;
`ifdef INPORT_BYPASS_EN
    sel_stb   = 1'b0;
    sel_pdata = '0;
`endif
    for (int k = 0; k < NPORTS; k++) begin
      if (int'(port_sel) == k) begin
        sel_full = port_full[k];
        sel_hold = hold[k*WIDTH +: WIDTH];
`ifdef INPORT_BYPASS_EN
        sel_stb   = port_stb[k];
        sel_pdata = port_data[k*WIDTH +: WIDTH];
`endif
      end
    end
  end

`ifdef INPORT_BYPASS_EN
  assign bypass_hit = ie && !sel_full && sel_stb;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    mux_out  = bus_d;
    in_stall = 1'b0;
    if (ie) begin
      if (sel_full) begin
        mux_out = sel_hold;
      end else if (bypass_hit) begin
`ifdef INPORT_BYPASS_EN
        mux_out = sel_pdata;
`endif
      end else begin
        in_stall = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    assign consume[k] = ie && port_full[k] && (int'(port_sel) == k);
    assign inhibit[k] = bypass_hit && (int'(port_sel) == k);

    inport_latch #(.WIDTH(WIDTH)) u_latch (
      .clk     (clk),
      .rst     (rst),
      .stb     (port_stb[k]),
      .din     (port_data[k*WIDTH +: WIDTH]),
      .consume (consume[k]),
      .inhibit (inhibit[k]),
      .ovr_clr (ovr_clr[k]),
      .dout    (hold[k*WIDTH +: WIDTH]),
      .full    (port_full[k]),
      .overrun (overrun[k])
    );
  end

endmodule
